// File: rtl/fp_mul_issue.sv
// ---------------------------------------------------------------------------
// fp_mul_issue
//
// Operand-issue stage in front of a sequential single-precision multiplier.
// Operand pairs arrive over a valid/ready handshake and are buffered in a
// DEPTH-entry FIFO. One pair is launched per multiply window of ISSUE_PERIOD
// cycles. The operands stay stable on mul_a/mul_b for the whole window, and
// each launch carries an incrementing tag.
//
// Optional feature macro: FP_SPECIAL_CLASS_EN
//   defined   : spec_zero/spec_inf/spec_nan classify the issued pair and are
//               registered with the operands at launch.
//   undefined : the spec_* outputs are tied to 0 and no classifier is built.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   ISSUE_PERIOD cycles between successive mul_start pulses (>= 2)
//   TAG_W        issue tag width
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  FIFO can accept (combinational, count < DEPTH)
//   in_a/in_b  in   IEEE-754 single operands
//   mul_start  out  one-cycle launch pulse to the multiplier
//   mul_a/b    out  issued operands, held between launches
//   mul_tag    out  tag of the pair currently in the multiplier
//   busy       out  HOLD state or FIFO non-empty
//   spec_*     out  special-case class of the issued pair
// ---------------------------------------------------------------------------
module fp_mul_issue #(
    parameter int DEPTH        = 4,
    parameter int ISSUE_PERIOD = 26,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             mul_start,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic [TAG_W-1:0] mul_tag,
    output logic             busy,
    output logic             spec_zero,
    output logic             spec_inf,
    output logic             spec_nan
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (ISSUE_PERIOD > 2) ? $clog2(ISSUE_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -----------------------------------------------------------------------
    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_cnt;
    logic          launch;

    assign in_ready = (count < CW'(DEPTH));
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign push     = in_valid && in_ready;
    assign pop      = launch;
    assign busy     = (state_q == HOLD) || (count != '0);

    // NOTE: storage has no reset; validity is tracked by count/pointers, so
    // clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    launch  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // The counter is leaving 1 for 0 on this edge. Deciding here,
                // rather than one cycle later, keeps launches exactly
                // ISSUE_PERIOD cycles apart (launch edge + P-1 hold edges).
                if (hold_cnt == HW'(1)) begin
                    state_d = (count != '0) ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                // Only entered with count > 0; nothing else pops the FIFO.
                launch  = 1'b1;
                state_d = HOLD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                hold_cnt <= HW'(ISSUE_PERIOD - 1);
            end else if (state_q == HOLD) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Launch registers: operands and tag change only on the launch edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_tag   <= '0;
        end else begin
            mul_start <= launch;
            if (launch) begin
                mul_a   <= mem[rd_ptr][63:32];
                mul_b   <= mem[rd_ptr][31:0];
                mul_tag <= mul_tag + TAG_W'(1);
            end
        end
    end

`ifdef FP_SPECIAL_CLASS_EN
    // -----------------------------------------------------------------------
    // Special-operand classification of the head pair, captured at launch.
    // Exponent 0 counts as zero, so denormals are treated as zero.
    // -----------------------------------------------------------------------
    logic [31:0] head_a;
    logic [31:0] head_b;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        cls_nan, cls_inf, cls_zero;

    assign head_a = mem[rd_ptr][63:32];
    assign head_b = mem[rd_ptr][31:0];

    assign a_nan  = (head_a[30:23] == 8'hFF) && (head_a[22:0] != '0);
    assign b_nan  = (head_b[30:23] == 8'hFF) && (head_b[22:0] != '0);
    assign a_inf  = (head_a[30:23] == 8'hFF) && (head_a[22:0] == '0);
    assign b_inf  = (head_b[30:23] == 8'hFF) && (head_b[22:0] == '0);
    assign a_zero = (head_a[30:23] == 8'h00);
    assign b_zero = (head_b[30:23] == 8'h00);

    // inf x 0 is invalid and yields NaN; the priority chain keeps the three
    // flags mutually exclusive.
    assign cls_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign cls_inf  = !cls_nan && (a_inf || b_inf);
    assign cls_zero = !cls_nan && !cls_inf && (a_zero || b_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_zero <= 1'b0;
            spec_inf  <= 1'b0;
            spec_nan  <= 1'b0;
        end else if (launch) begin
            spec_zero <= cls_zero;
            spec_inf  <= cls_inf;
            spec_nan  <= cls_nan;
        end
    end
`else
    assign spec_zero = 1'b0;
    assign spec_inf  = 1'b0;
    assign spec_nan  = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_issue.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_issue
//
// Directed self-checking bench for fp_mul_issue with DEPTH=4,
// ISSUE_PERIOD=26 and TAG_W=4. Inputs are driven and outputs sampled 1 time
// unit after each rising edge. The expected special-class flags follow the
// FP_SPECIAL_CLASS_EN macro, so the bench suits either build.
// ---------------------------------------------------------------------------
module tb_fp_mul_issue;

    localparam int DEPTH  = 4;
    localparam int PERIOD = 26;
    localparam int TAG_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             mul_start;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [TAG_W-1:0] mul_tag;
    logic             busy;
    logic             spec_zero;
    logic             spec_inf;
    logic             spec_nan;

    int tests  = 0;
    int errors = 0;

    fp_mul_issue #(
        .DEPTH       (DEPTH),
        .ISSUE_PERIOD(PERIOD),
        .TAG_W       (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_tag   (mul_tag),
        .busy      (busy),
        .spec_zero (spec_zero),
        .spec_inf  (spec_inf),
        .spec_nan  (spec_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        rst_n    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Push one pair; returns when the accepting edge has passed.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n        = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        if (n >= 200) begin
            tests++; errors++;
            $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
        end
    endtask

    task automatic wait_launch(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (mul_start) seen = 1'b1;
            else tick();
        end
        tests++;
        if (!seen) begin
            errors++;
            $display("FAIL launch_timeout: mul_start=%0b, required 1", mul_start);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b, required 0", busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        rst_n    = 1'b0;
        #2;
        tests++;
        if ({in_ready, mul_start, busy, spec_zero, spec_inf, spec_nan} !== 6'b100000 ||
            mul_a !== 32'h0 || mul_b !== 32'h0 || mul_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: rdy=%0b st=%0b busy=%0b a=%h b=%h tag=%0d flags=%0b%0b%0b, required rdy=1 all others 0",
                     in_ready, mul_start, busy, mul_a, mul_b, mul_tag, spec_zero, spec_inf, spec_nan);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (mul_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: st=%0b busy=%0b rdy=%0b, required 0 0 1",
                     mul_start, busy, in_ready);
        end
    endtask

    task automatic test_single();
        int n;
        int pulses;
        apply_reset();
        push_pair(32'h40400000, 32'h40000000);   // edge k
        tests++;
        if (mul_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_after_push: st=%0b busy=%0b, required 0 1", mul_start, busy);
        end
        tick();                                   // edge k+1
        tests++;
        if (mul_start !== 1'b1 || mul_a !== 32'h40400000 || mul_b !== 32'h40000000 ||
            mul_tag !== 4'd1) begin
            errors++;
            $display("FAIL single_launch: st=%0b a=%h b=%h tag=%0d, required 1 40400000 40000000 1",
                     mul_start, mul_a, mul_b, mul_tag);
        end
        n      = 2;
        pulses = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) break;
            n++;
            if (mul_start) pulses++;
        end
        tests++;
        if (n != PERIOD) begin
            errors++;
            $display("FAIL single_busy_len: busy cycles=%0d, required %0d", n, PERIOD);
        end
        tests++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL single_hold_quiet: pulses=%0d, required 1", pulses);
        end
        tests++;
        if (mul_a !== 32'h40400000 || mul_b !== 32'h40000000 || mul_tag !== 4'd1) begin
            errors++;
            $display("FAIL single_idle_hold: a=%h b=%h tag=%0d, required 40400000 40000000 1",
                     mul_a, mul_b, mul_tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [6];
        logic [31:0] pb [6];
        int  acc, launches, last_t, cyc;
        bit  rdy_s, full_checked;
        for (int i = 0; i < 6; i++) begin
            pa[i] = 32'h3F800000 + 32'(i);
            pb[i] = 32'h40A00000 + 32'(i * 16);
        end
        apply_reset();
        acc = 0; launches = 0; last_t = 0; cyc = 0; full_checked = 0;
        in_valid = 1'b1;
        in_a     = pa[0];
        in_b     = pb[0];
        rdy_s    = in_ready;
        while (launches < 6 && cyc < 400) begin
            @(posedge clk);
            if (in_valid && rdy_s) acc++;
            #1;
            cyc++;
            if (mul_start) begin
                tests++;
                if (mul_tag !== 4'(launches + 1) || mul_a !== pa[launches] || mul_b !== pb[launches]) begin
                    errors++;
                    $display("FAIL burst_launch%0d: tag=%0d a=%h b=%h, required %0d %h %h",
                             launches, mul_tag, mul_a, mul_b, launches + 1, pa[launches], pb[launches]);
                end
                if (launches > 0) begin
                    tests++;
                    if (cyc - last_t != PERIOD) begin
                        errors++;
                        $display("FAIL burst_spacing%0d: gap=%0d, required %0d",
                                 launches, cyc - last_t, PERIOD);
                    end
                end
                last_t = cyc;
                launches++;
            end
            if (acc == 5 && !full_checked) begin
                full_checked = 1;
                tests++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_full_ready: in_ready=%0b, required 0", in_ready);
                end
            end
            if (acc < 6) begin
                in_a = pa[acc];
                in_b = pb[acc];
            end else begin
                in_valid = 1'b0;
            end
            rdy_s = in_ready;
        end
        in_valid = 1'b0;
        tests++;
        if (launches != 6) begin
            errors++;
            $display("FAIL burst_count: launches=%0d, required 6", launches);
        end
        wait_idle();
    endtask

    task automatic test_full_pop();
        int  acc, launches, cyc;
        bit  rdy_s;
        apply_reset();
        acc = 0; launches = 0; cyc = 0;
        in_valid = 1'b1;
        in_a     = 32'h41000000;
        in_b     = 32'h41100000;
        rdy_s    = in_ready;
        // Fill to count=4 (five accepts, one already popped), keep in_valid
        // high and wait for the second launch, which pops from a full FIFO.
        while (launches < 2 && cyc < 100) begin
            @(posedge clk);
            if (in_valid && rdy_s && acc < 5) acc++;
            #1;
            cyc++;
            if (mul_start) launches++;
            rdy_s = in_ready;
        end
        in_valid = 1'b0;
        tests++;
        if (launches != 2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_ready: launches=%0d in_ready=%0b, required 2 1", launches, in_ready);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_count3: in_ready=%0b busy=%0b, required 1 1", in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit seen;
        int pulses;
        apply_reset();
        in_valid = 1'b1;
        in_a     = 32'h40800000;
        in_b     = 32'h40800000;
        repeat (3) tick();            // three accepts; first already launched
        in_valid = 1'b0;
        tests++;
        if (mul_tag !== 4'd1) begin
            errors++;
            $display("FAIL midhold_first_tag: tag=%0d, required 1", mul_tag);
        end
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, mul_start, busy, spec_zero, spec_inf, spec_nan} !== 6'b100000 ||
            mul_a !== 32'h0 || mul_b !== 32'h0 || mul_tag !== 4'h0) begin
            errors++;
            $display("FAIL midhold_reset_values: rdy=%0b st=%0b busy=%0b a=%h b=%h tag=%0d, required 1 0 0 0 0 0",
                     in_ready, mul_start, busy, mul_a, mul_b, mul_tag);
        end
        repeat (3) tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mul_start || busy) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midhold_no_issue: active cycles=%0d, required 0", pulses);
        end
        push_pair(32'h3F800000, 32'h3F800000);
        wait_launch(seen);
        tests++;
        if (mul_tag !== 4'd1) begin
            errors++;
            $display("FAIL midhold_restart_tag: tag=%0d, required 1", mul_tag);
        end
        wait_idle();
    endtask

    task automatic test_special();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [2:0]  exp_f [4];   // {zero, inf, nan}
        bit seen;
        va[0] = 32'h7F800000; vb[0] = 32'h00000000;
        va[1] = 32'h7F800000; vb[1] = 32'h3F800000;
        va[2] = 32'h00000000; vb[2] = 32'h3F800000;
        va[3] = 32'h3F800000; vb[3] = 32'h3F800000;
`ifdef FP_SPECIAL_CLASS_EN
        exp_f[0] = 3'b001; exp_f[1] = 3'b010; exp_f[2] = 3'b100; exp_f[3] = 3'b000;
`else
        exp_f[0] = 3'b000; exp_f[1] = 3'b000; exp_f[2] = 3'b000; exp_f[3] = 3'b000;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_pair(va[i], vb[i]);
            wait_launch(seen);
            tests++;
            if ({spec_zero, spec_inf, spec_nan} !== exp_f[i]) begin
                errors++;
                $display("FAIL special%0d: zin=%b, required %b", i, {spec_zero, spec_inf, spec_nan}, exp_f[i]);
            end
            wait_idle();
            tests++;
            if ({spec_zero, spec_inf, spec_nan} !== exp_f[i]) begin
                errors++;
                $display("FAIL special%0d_hold: zin=%b, required %b", i, {spec_zero, spec_inf, spec_nan}, exp_f[i]);
            end
        end
    endtask

    task automatic test_tag_wrap();
        int  acc, launches, cyc;
        bit  rdy_s;
        logic [TAG_W-1:0] exp_tag;
        apply_reset();
        acc = 0; launches = 0; cyc = 0;
        in_valid = 1'b1;
        in_a     = 32'h40000000;
        in_b     = 32'h40000000;
        rdy_s    = in_ready;
        while (launches < 17 && cyc < 600) begin
            @(posedge clk);
            if (in_valid && rdy_s) acc++;
            #1;
            cyc++;
            if (mul_start) begin
                launches++;
                exp_tag = TAG_W'(launches);   // 16th -> 0, 17th -> 1
                tests++;
                if (mul_tag !== exp_tag) begin
                    errors++;
                    $display("FAIL tag_wrap%0d: tag=%0d, required %0d", launches, mul_tag, exp_tag);
                end
            end
            if (acc >= 17) in_valid = 1'b0;
            rdy_s = in_ready;
        end
        in_valid = 1'b0;
        tests++;
        if (launches != 17) begin
            errors++;
            $display("FAIL tag_wrap_count: launches=%0d, required 17", launches);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_hold();
        test_special();
        test_tag_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_issue.md
# fp_mul_issue

Operand-issue stage placed directly upstream of the 24-cycle-class sequential single-precision multiplier. Accepts IEEE-754 single-precision operand pairs over a valid/ready handshake and buffers them in a small FIFO. Launches one pair into the multiplier per multiply window, holding the operands stable for the whole window and tagging each issue so downstream logic can match results. Optionally classifies special operands (zero/inf/NaN) so a result stage can bypass the mantissa product.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ISSUE_PERIOD, 26, cycles between successive mul_start pulses; ≥2
- TAG_W, 4, issue tag width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept; combinational, equals count < DEPTH
- in_a  in  32  IEEE single operand A
- in_b  in  32  IEEE single operand B
- mul_start  out  1  one-cycle launch pulse to multiplier
- mul_a  out  32  operand A, held stable between launches
- mul_b  out  32  operand B, held stable between launches
- mul_tag  out  TAG_W  tag of pair currently in multiplier
- busy  out  1  HOLD state or FIFO non-empty
- spec_zero / spec_inf / spec_nan  out  1 each  special-case class of issued pair (see Configuration)

## Operation
- FIFO: DEPTH entries of {in_a, in_b}; wr/rd pointers wrap modulo DEPTH; count is 0..DEPTH.
- Push when in_valid && in_ready. Pop only when the FSM issues. Simultaneous push and pop leave count unchanged. No push when full, even if a pop happens in the same cycle. No bypass when empty.
- FSM states:
  - IDLE: if count>0, pop the head into mul_a/mul_b, pulse mul_start, increment tag (wraps at 2^TAG_W), load hold counter with ISSUE_PERIOD-1, go HOLD. Otherwise stay in IDLE.
  - HOLD: decrement the counter each cycle. When it reaches 0, go to ISSUE if count>0, else IDLE.
  - ISSUE: same actions as the IDLE launch, then go HOLD.
  - Result: back-to-back launches are spaced exactly ISSUE_PERIOD cycles apart.
- mul_a, mul_b and mul_tag change only in the launch cycle. They hold their values in IDLE after the last issue.
- Reset (any time, including mid-HOLD): FIFO emptied, pointers and count 0, state IDLE, tag 0. Any in-flight multiply is abandoned; the downstream stage is reset by the same net.

## Timing
- Reset values: in_ready=1, mul_start=0, mul_a=0, mul_b=0, mul_tag=0, busy=0, spec_*=0.
- A pair pushed at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. mul_start is high for the single cycle after edge k+1, and mul_a/mul_b are valid in that same cycle (latency 1 cycle push-to-launch).
- While in HOLD, mul_start stays 0 for ISSUE_PERIOD-1 cycles.
- in_ready deasserts in the cycle after the push that makes count=DEPTH. It reasserts in the cycle after the next pop.
- mul_tag of the first issue after reset is 1.

## Configuration
- FP_SPECIAL_CLASS_EN defined: registered together with mul_a/mul_b at launch, for the issued pair:
  - spec_nan = either operand NaN (exp=255, mant≠0), or one operand inf (exp=255, mant=0) while the other has exp=0
  - spec_inf = !spec_nan && either operand inf
  - spec_zero = !spec_nan && !spec_inf && either operand exp=0
  - Flags are mutually exclusive and hold until the next launch.
- FP_SPECIAL_CLASS_EN undefined: spec_zero/spec_inf/spec_nan tied to 0; no classification logic.

## Test plan
- Single pair: in_a=0x40400000 (3.0), in_b=0x40000000 (2.0) pushed at edge 5 → mul_start high in the cycle after edge 6, mul_a=0x40400000, mul_b=0x40000000, mul_tag=1, busy=1 for 26 cycles then 0.
- Burst of 6 pairs, in_valid held high, DEPTH=4 → in_ready low after the 4th accepted push (plus the 1 already popped). Launches occur at cycles t, t+26, t+52, … with tags 1..6 in order and operands in push order.
- Full plus pop in the same cycle: count=4, in_valid=1 on the launch edge → no push; count becomes 3 and in_ready=1 on the next cycle.
- Reset mid-HOLD: rst_n low 10 cycles after a launch with 2 pairs queued → all outputs return to reset values immediately; no further mul_start after release until a new push.
- With FP_SPECIAL_CLASS_EN:
  - 0x7F800000 × 0x00000000 → spec_nan=1
  - 0x7F800000 × 0x3F800000 → spec_inf=1
  - 0x00000000 × 0x3F800000 → spec_zero=1
  - 0x3F800000 × 0x3F800000 → all flags 0
  - Without the macro, every case gives all flags 0.
- Tag wrap: 17 launches with TAG_W=4 → the 16th launch shows mul_tag=0 and the 17th shows mul_tag=1.
